// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from a FIFO (8N1, LSB first).
// One read pulse per byte; tx and tx_done are registered, so they lag the FSM by one cycle.
//
// state | meaning
// IDLE  | line idle; request a byte when the FIFO is not empty
// FETCH | capture the byte returned by the FIFO
// START | start bit (low)
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); tx_done marks its last cycle
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty,
    input  logic [7:0] fifo_data,
    output logic       RDEN,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        done_d  = 1'b0;
        RDEN    = 1'b0;
        case (state_q)
            IDLE: begin
                // Reset also masks the request so no byte is popped during reset.
                if (!empty && !rst) begin
                    RDEN    = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                shift_d = fifo_data;
                cnt_d   = '0;
                idx_d   = '0;
                state_d = START;
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_done = done_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: table-driven frames, directed corner sequences and
// randomized FIFO traffic checked every cycle against a frame-timing model.
module tb_fifo_uart_tx;

    localparam int CPB      = 4;
    localparam int FRAME    = 10 * CPB;
    localparam int DONE_OFS = 2 + FRAME;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       RDEN;
    logic       tx;
    logic       busy;
    logic       tx_done;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .empty     (empty),
        .fifo_data (fifo_data),
        .RDEN      (RDEN),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] bits;
    } vec_t;

    vec_t       tbl[5];
    logic [7:0] q[$];
    logic       hold_empty = 1'b0;
    bit         mon_en = 1'b0;
    logic       rden_prev = 1'b0;
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    int         rden_count = 0;
    int         last_rden_cyc = -1;
    int         last_done_cyc = -1;
    int         viol = 0;

    // Model: the most recent frame, identified by its read-request cycle.
    int         m_r = -1000;
    int         m_end = -1000;
    int         m_done = -1;
    int         m_free = 0;
    logic [7:0] m_data = 8'h00;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (rden_prev) begin
            if (q.size() > 0) fifo_data = q.pop_front();
            else fifo_data = 8'h00;
        end else begin
            fifo_data = 8'($urandom);
        end
        empty = hold_empty || (q.size() == 0);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic monitor_step();
        int  k;
        int  j;
        int  exp_rden;
        int  exp_tx;
        int  exp_busy;
        int  exp_done;
        exp_rden = (!rst && !empty && cyc >= m_free) ? 1 : 0;
        if (mon_en) begin
            k = cyc - m_r - 3;
            exp_tx = 1;
            if (k >= 0 && k < FRAME && cyc <= m_end) begin
                j = k / CPB;
                if (j == 0) exp_tx = 0;
                else if (j == 9) exp_tx = 1;
                else exp_tx = int'(m_data[j-1]);
            end
            exp_busy = (cyc >= m_r + 1 && cyc <= m_r + 1 + FRAME && cyc <= m_end) ? 1 : 0;
            exp_done = (cyc == m_done) ? 1 : 0;
            check("rden", int'(RDEN), exp_rden);
            check("tx", int'(tx), exp_tx);
            check("busy", int'(busy), exp_busy);
            check("tx_done", int'(tx_done), exp_done);
            if (RDEN && empty) viol++;
            if (RDEN && rden_prev) viol++;
        end
        if (RDEN) begin
            rden_count++;
            last_rden_cyc = cyc;
        end
        if (tx_done) last_done_cyc = cyc;
        if (cyc == m_r + 1) m_data = fifo_data;
        if (rst) begin
            m_free = cyc + 1;
            if (m_end > cyc) m_end = cyc;
            if (m_done > cyc) m_done = -1;
        end else if (exp_rden == 1) begin
            m_r    = cyc;
            m_end  = cyc + DONE_OFS;
            m_done = cyc + DONE_OFS;
            m_free = cyc + DONE_OFS;
        end
        rden_prev = RDEN;
    endtask

    task automatic wait_rden(input string name, output int r);
        int start;
        int n;
        start = rden_count;
        n = 0;
        while (rden_count == start && n < 200) begin
            tick();
            n++;
        end
        check({name, "_rden_seen"}, int'(rden_count != start), 1);
        r = last_rden_cyc;
    endtask

    task automatic capture(input int r, output logic [9:0] bits);
        bits = '1;
        for (int k = 0; k < 10; k++) begin
            wait_until(r + 3 + CPB * k + 1);
            bits[k] = tx;
        end
    endtask

    initial begin
        int         r;
        int         r2;
        int         start;
        int         bad;
        int         n;
        logic [9:0] bits;

        tbl[0] = '{8'hA5, 10'b1_1010_0101_0};
        tbl[1] = '{8'h00, 10'b1_0000_0000_0};
        tbl[2] = '{8'hFF, 10'b1_1111_1111_0};
        tbl[3] = '{8'h3C, 10'b1_0011_1100_0};
        tbl[4] = '{8'h81, 10'b1_1000_0001_0};

        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        tick();
        tick();
        mon_en = 1'b1;
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_tx_done", int'(tx_done), 0);
        check("reset_rden", int'(RDEN), 0);
        rst = 1'b0;

        // Empty FIFO: line must stay idle.
        start = rden_count;
        bad = 0;
        repeat (100) begin
            tick();
            if (RDEN || !tx || busy) bad++;
        end
        check("idle_quiet_cycles", bad, 0);
        check("idle_rden_count", rden_count - start, 0);

        foreach (tbl[i]) begin
            start = rden_count;
            q.push_back(tbl[i].data);
            wait_rden($sformatf("tbl%0d", i), r);
            capture(r, bits);
            check($sformatf("tbl%0d_bits", i), int'(bits), int'(tbl[i].bits));
            wait_until(r + DONE_OFS + 2);
            check($sformatf("tbl%0d_done_ofs", i), last_done_cyc - r, DONE_OFS);
            check($sformatf("tbl%0d_rden_pulses", i), rden_count - start, 1);
        end

        // Back-to-back 00 then FF.
        q.push_back(8'h00);
        q.push_back(8'hFF);
        wait_rden("b2b_first", r);
        capture(r, bits);
        check("b2b_first_bits", int'(bits), int'(10'b1_0000_0000_0));
        wait_rden("b2b_second", r2);
        check("b2b_rden_spacing", r2 - r, DONE_OFS);
        wait_until(r + DONE_OFS);
        check("b2b_stop_last", int'(tx), 1);
        wait_until(r + DONE_OFS + 1);
        check("b2b_gap1", int'(tx), 1);
        wait_until(r + DONE_OFS + 2);
        check("b2b_gap2", int'(tx), 1);
        wait_until(r + DONE_OFS + 3);
        check("b2b_next_start", int'(tx), 0);
        capture(r2, bits);
        check("b2b_second_bits", int'(bits), int'(10'b1_1111_1111_0));
        wait_until(r2 + DONE_OFS + 2);

        // Reset during data bit 3, byte pushed while reset is held.
        q.push_back(8'h5A);
        wait_rden("rst", r);
        wait_until(r + 6 + 3 * CPB + 1);
        rst = 1'b1;
        tick();
        check("rst_tx_high", int'(tx), 1);
        check("rst_busy_low", int'(busy), 0);
        q.push_back(8'hC3);
        start = rden_count;
        tick();
        tick();
        check("rst_blocks_rden", rden_count - start, 0);
        r2 = cyc;
        rst = 1'b0;
        wait_rden("rst_fresh", r);
        check("rst_fresh_rden_cycle", r - r2, 0);
        capture(r, bits);
        check("rst_fresh_bits", int'(bits), int'(10'b1_1100_0011_0));
        wait_until(r + DONE_OFS + 2);
        check("rst_fresh_done_ofs", last_done_cyc - r, DONE_OFS);

        // empty rises in FETCH (queue drains), falls again during STOP.
        q.push_back(8'h96);
        wait_rden("emp", r);
        capture(r, bits);
        check("emp_first_bits", int'(bits), int'(10'b1_1001_0110_0));
        q.push_back(8'h69);
        wait_rden("emp_next", r2);
        check("emp_next_rden_cycle", r2 - r, DONE_OFS);
        capture(r2, bits);
        check("emp_next_bits", int'(bits), int'(10'b1_0110_1001_0));
        wait_until(r2 + DONE_OFS + 2);

        // Random traffic, empty masking and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            tick();
            if ($urandom_range(0, 7) == 0 && q.size() < 3) q.push_back(8'($urandom));
            if ($urandom_range(0, 19) == 0) hold_empty = ~hold_empty;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
        end
        hold_empty = 1'b0;
        rst = 1'b0;
        n = 0;
        while ((q.size() != 0 || busy) && n < 2000) begin
            tick();
            n++;
        end
        check("random_drain", q.size(), 0);
        repeat (4) tick();

        check("rden_protocol", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
